// File: rtl/pb_pkg.sv
// Shared protobuf field-type constants and the varint read FSM state type.
package pb_pkg;

  localparam int MAX_VARINT_BYTES = 10;

  localparam logic [4:0] FT_SINT32 = 5'd17;
  localparam logic [4:0] FT_SINT64 = 5'd18;

  typedef enum logic [2:0] {
    IDLE,
    WAIT1,
    REQ2,
    WAIT2,
    FIN,
    HOLD
  } state_t;

  // Field types whose decoded value is truncated to 32 bits without zigzag.
  function automatic logic is_32bit_type(input logic [4:0] ft);
    return (ft == 5'd2) || (ft == 5'd5) || (ft == 5'd7) ||
           (ft == 5'd13) || (ft == 5'd15);
  endfunction

endpackage

// File: rtl/varint_deser_rd_if.sv
// 8-lane DRAM read port used by the varint reader.
interface varint_deser_rd_if;

  logic [7:0]       dram_en;
  logic [7:0][63:0] dram_addr;
  logic             dram_rdwr;
  logic [7:0][7:0]  dram_rdata;

  modport master (
    output dram_en,
    output dram_addr,
    output dram_rdwr,
    input  dram_rdata
  );

  modport slave (
    input  dram_en,
    input  dram_addr,
    input  dram_rdwr,
    output dram_rdata
  );

endinterface

// File: rtl/varint_deser.sv
// Combinational varint decoder: up to 10 bytes in, raw value, length and
// malformed flag out.
module varint_deser
  import pb_pkg::*;
(
  input  logic [MAX_VARINT_BYTES-1:0][7:0] bytes,
  output logic [63:0]                      raw,
  output logic [3:0]                       len,
  output logic                             err
);

  logic found;

  // Byte 9 shifted by 63 keeps only its bit 0; the rest falls off the top.
  always_comb begin
    raw   = '0;
    len   = 4'(MAX_VARINT_BYTES);
    err   = 1'b1;
    found = 1'b0;
    for (int k = 0; k < MAX_VARINT_BYTES; k++) begin
      if (!found) begin
        raw = raw | (64'(bytes[k][6:0]) << (7 * k));
        if (!bytes[k][7]) begin
          found = 1'b1;
          len   = 4'(k + 1);
          err   = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/varint_deser_rd.sv
// Reads one protobuf varint from DRAM (one 8-lane read, plus a 2-lane read
// when needed), decodes it per field type and pulses done.
module varint_deser_rd
  import pb_pkg::*;
#(
  parameter int RD_LAT = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [63:0]              src_addr,
  input  logic [4:0]               field_type,
  varint_deser_rd_if.master        dram,
  output logic [63:0]              value,
  output logic [3:0]               bytes_read,
  output logic                     error,
  output logic                     done
);

  localparam int CNT_W = $clog2(RD_LAT + 2) + 1;
  // The second read is given one extra counter step so done lands at
  // 2*RD_LAT+4 while the first read lands at RD_LAT+2.
  localparam logic [CNT_W-1:0] LAT1 = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] LAT2 = CNT_W'(RD_LAT);

  state_t                                 state, state_nx;
  logic [CNT_W-1:0]                       cnt;
  logic [MAX_VARINT_BYTES-1:0][7:0]       byte_buf;
  logic                                   issue1, issue2, cap1, cap2, fin;
  logic                                   term_in_first;

  logic [63:0] raw;
  logic [3:0]  len;
  logic        err;
  logic [63:0] zz64;
  logic [31:0] zz32;
  logic [63:0] dec;

  varint_deser u_deser (
    .bytes (byte_buf),
    .raw   (raw),
    .len   (len),
    .err   (err)
  );

  always_comb begin
    term_in_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!dram.dram_rdata[i][7]) term_in_first = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    issue1   = 1'b0;
    issue2   = 1'b0;
    cap1     = 1'b0;
    cap2     = 1'b0;
    fin      = 1'b0;
    if (!en && state != IDLE) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            issue1   = 1'b1;
            state_nx = WAIT1;
          end
        end
        WAIT1: begin
          if (cnt == LAT1) begin
            cap1     = 1'b1;
            state_nx = term_in_first ? FIN : REQ2;
          end
        end
        REQ2: begin
          issue2   = 1'b1;
          state_nx = WAIT2;
        end
        WAIT2: begin
          if (cnt == LAT2) begin
            cap2     = 1'b1;
            state_nx = FIN;
          end
        end
        FIN: begin
          fin      = 1'b1;
          state_nx = HOLD;
        end
        HOLD:    state_nx = HOLD;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    zz64 = (raw >> 1) ^ (-(raw & 64'd1));
    zz32 = (raw[31:0] >> 1) ^ (-(raw[31:0] & 32'd1));
    if (field_type == FT_SINT64)      dec = zz64;
    else if (field_type == FT_SINT32) dec = {32'd0, zz32};
    else if (is_32bit_type(field_type)) dec = {32'd0, raw[31:0]};
    else                              dec = raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dram.dram_en   <= '0;
      dram.dram_addr <= '0;
      dram.dram_rdwr <= 1'b0;
      cnt            <= '0;
      byte_buf       <= '0;
      value          <= '0;
      bytes_read     <= '0;
      error          <= 1'b0;
      done           <= 1'b0;
    end else begin
      done           <= fin;
      dram.dram_rdwr <= issue1 | issue2;
      dram.dram_en   <= issue1 ? 8'hFF : (issue2 ? 8'h03 : 8'h00);

      if (issue1) begin
        for (int i = 0; i < 8; i++) dram.dram_addr[i] <= src_addr + 64'(i);
        value          <= '0;
        bytes_read     <= '0;
        error          <= 1'b0;
        byte_buf[9:8]  <= '0;
      end else if (issue2) begin
        dram.dram_addr    <= '0;
        dram.dram_addr[0] <= src_addr + 64'd8;
        dram.dram_addr[1] <= src_addr + 64'd9;
      end

      if (issue1 || issue2)                cnt <= '0;
      else if (state == WAIT1 || state == WAIT2) cnt <= cnt + 1'b1;

      if (cap1) byte_buf[7:0] <= dram.dram_rdata;
      if (cap2) byte_buf[9:8] <= dram.dram_rdata[1:0];

      if (fin) begin
        value      <= dec;
        bytes_read <= len;
        error      <= err;
      end
    end
  end

endmodule
